fsb_cycle_ctl: RTL

//  FSB cycle sequencer. Terminates every 68HC000 front-side-bus cycle with nDTACK_FSB or nBERR_FSB.
//  Per-device wait states come from the chip-select decoder outputs. I/O cycles wait on the IOB slave bridge.

---
 rtl/fsb_cycle_ctl_pkg.sv | 51 +++++
 rtl/fsb_cycle_ctl_if.sv | 25 ++
 rtl/fsb_cycle_ctl_ws_cnt.sv | 39 +++
 rtl/fsb_cycle_ctl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fsb_cycle_ctl_pkg.sv
// Shared types for the FSB cycle sequencer: FSM states, device classes,
// counter modes and the select-decode / wait-state helpers.
package fsb_cyc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      IOWAIT,
      UNMAP,
      ACK,
      ERR
   } state_e;

   typedef enum logic [2:0] {
      CLS_RAM,
      CLS_ROM,
      CLS_SND,
      CLS_IO,
      CLS_NONE
   } dev_cls_e;

   // Clearing the timeout counter is a load of zero.
   typedef enum logic [1:0] {
      CNT_HOLD,
      CNT_LOAD,
      CNT_DEC,
      CNT_INC
   } cnt_mode_e;

   function automatic dev_cls_e decode_cls(input logic iocs, input logic snd,
                                           input logic rom, input logic ram);
      if (iocs)      return CLS_IO;
      else if (snd)  return CLS_SND;
      else if (rom)  return CLS_ROM;
      else if (ram)  return CLS_RAM;
      else           return CLS_NONE;
   endfunction

   function automatic int unsigned cls_ws(input dev_cls_e cls,
                                          input int unsigned ram_ws,
                                          input int unsigned rom_ws,
                                          input int unsigned snd_ws);
      case (cls)
         CLS_RAM: return ram_ws;
         CLS_ROM: return rom_ws;
         CLS_SND: return snd_ws;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/fsb_cycle_ctl_if.sv
// CPU-side bus of the FSB cycle sequencer: strobe, chip selects, IOB bridge
// status in; termination pins and status out.
interface fsb_cycle_ctl_if;
   logic nAS_FSB;
   logic RAMCS;
   logic ROMCS;
   logic SndRAMCSWR;
   logic IOCS;
   logic Ready_IOBS;
   logic nBERR_IOB;
   logic nDTACK_FSB;
   logic nBERR_FSB;
   logic Busy;
   logic ErrIO;

   modport master (
      output nAS_FSB, RAMCS, ROMCS, SndRAMCSWR, IOCS, Ready_IOBS, nBERR_IOB,
      input  nDTACK_FSB, nBERR_FSB, Busy, ErrIO
   );

   modport slave (
      input  nAS_FSB, RAMCS, ROMCS, SndRAMCSWR, IOCS, Ready_IOBS, nBERR_IOB,
      output nDTACK_FSB, nBERR_FSB, Busy, ErrIO
   );
endinterface

// File: rtl/fsb_cycle_ctl_ws_cnt.sv
// Loadable counter shared by the wait-state and timeout paths: load,
// decrement stopping at zero, or increment saturating at TERM.
module fsb_ws_cnt
   import fsb_cyc_pkg::*;
#(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned TERM  = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  cnt_mode_e        mode_i,
   input  logic [CNT_W-1:0] load_i,
   output logic             zero_o,
   output logic             term_o
);

   localparam logic [CNT_W-1:0] TERM_V = CNT_W'(TERM);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples its inputs from before the edge, independent of block order.
         cnt_q <= '0;
      end else begin
         case (mode_i)
            CNT_LOAD: cnt_q <= load_i;
            CNT_DEC:  if (cnt_q != '0)     cnt_q <= cnt_q - 1'b1;
            CNT_INC:  if (cnt_q != TERM_V) cnt_q <= cnt_q + 1'b1;
            default:  cnt_q <= cnt_q;
         endcase
      end
   end

   assign zero_o = (cnt_q == '0);
   assign term_o = (cnt_q == TERM_V);

endmodule

// File: rtl/fsb_cycle_ctl.sv
// FSB cycle sequencer: accepts each 68HC000 address strobe and terminates the
// cycle with DTACK after the device wait states, or BERR on IOB error/timeout.
module fsb_cycle_ctl
   import fsb_cyc_pkg::*;
#(
   parameter int unsigned RAM_WS = 0,
   parameter int unsigned ROM_WS = 2,
   parameter int unsigned SND_WS = 1,
   parameter int unsigned TO_CYC = 255,
   parameter int unsigned CNT_W  = 8
) (
   input  logic           CLK_FSB,
   input  logic           nRES,
   fsb_cycle_ctl_if.slave bus
);

   localparam bit PARAM_OK = ((TO_CYC >> CNT_W) == 0) && (RAM_WS < TO_CYC) &&
                             (ROM_WS < TO_CYC) && (SND_WS < TO_CYC);

   generate
      if (!PARAM_OK) begin : g_param_err
         $error("fsb_cycle_ctl: CNT_W too narrow for TO_CYC or a wait state >= TO_CYC");
      end
   endgenerate

   state_e           state_q;
   logic             dtack_n_q;
   logic             berr_n_q;
   logic             busy_q;
   logic             err_io_q;

   dev_cls_e         cls_now;
   logic             as_low;
   cnt_mode_e        wait_mode;
   cnt_mode_e        to_mode;
   logic [CNT_W-1:0] wait_load;
   logic             wait_zero;
   logic             wait_term;
   logic             to_zero;
   logic             to_term;
   logic             unused_flags;

   assign as_low  = !bus.nAS_FSB;
   assign cls_now = decode_cls(bus.IOCS, bus.SndRAMCSWR, bus.ROMCS, bus.RAMCS);

   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // through the case leaves a value held, which would infer a latch.
      wait_mode = CNT_HOLD;
      to_mode   = CNT_HOLD;
      wait_load = CNT_W'(cls_ws(cls_now, RAM_WS, ROM_WS, SND_WS));
      case (state_q)
         IDLE: begin
            if (as_low) begin
               if (cls_now == CLS_IO || cls_now == CLS_NONE) to_mode   = CNT_LOAD;
               else                                          wait_mode = CNT_LOAD;
            end
         end
         WAIT:          if (as_low) wait_mode = CNT_DEC;
         IOWAIT, UNMAP: if (as_low) to_mode   = CNT_INC;
         default: ;
      endcase
   end

   fsb_ws_cnt #(.CNT_W(CNT_W), .TERM(TO_CYC)) u_wait_cnt (
      .clk    (CLK_FSB),
      .rst_n  (nRES),
      .mode_i (wait_mode),
      .load_i (wait_load),
      .zero_o (wait_zero),
      .term_o (wait_term)
   );

   fsb_ws_cnt #(.CNT_W(CNT_W), .TERM(TO_CYC)) u_to_cnt (
      .clk    (CLK_FSB),
      .rst_n  (nRES),
      .mode_i (to_mode),
      .load_i ('0),
      .zero_o (to_zero),
      .term_o (to_term)
   );

   assign unused_flags = wait_term | to_zero;

   // An AS negation before termination aborts the cycle, even on the edge
   // where the wait count would otherwise have completed.
   always_ff @(posedge CLK_FSB or negedge nRES) begin
      if (!nRES) begin
         state_q   <= IDLE;
         dtack_n_q <= 1'b1;
         berr_n_q  <= 1'b1;
         busy_q    <= 1'b0;
         err_io_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (as_low) begin
                  busy_q <= 1'b1;
                  case (cls_now)
                     CLS_IO:   state_q <= IOWAIT;
                     CLS_NONE: state_q <= UNMAP;
                     default:  state_q <= WAIT;
                  endcase
               end
            end
            WAIT: begin
               if (!as_low) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (wait_zero) begin
                  state_q   <= ACK;
                  dtack_n_q <= 1'b0;
               end
            end
            IOWAIT: begin
               if (!as_low) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (bus.Ready_IOBS) begin
                  state_q   <= ACK;
                  dtack_n_q <= 1'b0;
               end else if (!bus.nBERR_IOB) begin
                  state_q  <= ERR;
                  berr_n_q <= 1'b0;
                  err_io_q <= 1'b1;
               end else if (to_term) begin
                  state_q  <= ERR;
                  berr_n_q <= 1'b0;
                  err_io_q <= 1'b0;
               end
            end
            UNMAP: begin
               if (!as_low) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (to_term) begin
                  state_q  <= ERR;
                  berr_n_q <= 1'b0;
                  err_io_q <= 1'b0;
               end
            end
            ACK, ERR: begin
               if (!as_low) begin
                  state_q   <= IDLE;
                  dtack_n_q <= 1'b1;
                  berr_n_q  <= 1'b1;
                  busy_q    <= 1'b0;
               end
            end
            default: begin
               state_q   <= IDLE;
               dtack_n_q <= 1'b1;
               berr_n_q  <= 1'b1;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.nDTACK_FSB = dtack_n_q;
   assign bus.nBERR_FSB  = berr_n_q;
   assign bus.Busy       = busy_q;
   assign bus.ErrIO      = err_io_q;

endmodule
